// File: rtl/dsc_stream_decoder.sv
// DSC stream decoder: counts ones over a 2^(NUM_INPUTS*SNG_WIDTH)-sample window, presents count + rescaled value on valid/ready.
// Optional macro DSC_DEC_ROUND_EN selects round-half-up rescaling instead of truncation.
module dsc_stream_decoder #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                start,
  input  logic                                en,
  input  logic                                sn_in,
  output logic                                busy,
  output logic [NUM_INPUTS*SNG_WIDTH:0]       z,
  output logic [SNG_WIDTH-1:0]                z_scaled,
  output logic                                z_valid,
  input  logic                                z_ready,
  output logic                                ovr
);

  localparam int CW        = NUM_INPUTS * SNG_WIDTH;
  localparam int SHIFT     = CW - SNG_WIDTH;
  localparam int ROUND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CW+1:0] HALF       = (SHIFT > 0) ? ((CW+2)'(1) << ROUND_POS) : '0;
  localparam logic [CW+1:0] MAX_SCALED = (CW+2)'((1 << SNG_WIDTH) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, next_state;
  logic [CW:0]     acc;
  logic [CW-1:0]   wcnt;
  logic [CW:0]     sample_sum;
  logic            win_end;

  // A full count of 2^CW would overflow the SNG_WIDTH-bit result, hence the saturation.
  function automatic logic [SNG_WIDTH-1:0] scale(input logic [CW:0] n);
    logic [CW+1:0] t;
    t = {1'b0, n};
`ifdef DSC_DEC_ROUND_EN
    t = t + HALF;
`endif
    t = t >> SHIFT;
    if (t > MAX_SCALED) return MAX_SCALED[SNG_WIDTH-1:0];
    return t[SNG_WIDTH-1:0];
  endfunction

  assign sample_sum = acc + (CW+1)'(sn_in);
  assign win_end    = (state == RUN) && en && (wcnt == '1);
  assign busy       = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)   next_state = RUN;
        RUN:     if (win_end) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Accumulator, window counter and the handshaked result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      wcnt     <= '0;
      z        <= '0;
      z_scaled <= '0;
      z_valid  <= 1'b0;
      ovr      <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      wcnt     <= '0;
      z        <= '0;
      z_scaled <= '0;
      z_valid  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc  <= '0;
        wcnt <= '0;
      end else if (state == RUN && en) begin
        wcnt <= wcnt + CW'(1);
        acc  <= win_end ? '0 : sample_sum;
      end

      if (win_end) begin
        z        <= sample_sum;
        z_scaled <= scale(sample_sum);
        z_valid  <= 1'b1;
        if (z_valid && !z_ready) ovr <= 1'b1;
      end else if (z_valid && z_ready) begin
        z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsc_stream_decoder.sv
// Directed testbench for dsc_stream_decoder with SNG_WIDTH=2, NUM_INPUTS=2 (16-sample window).
module tb_dsc_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       start;
  logic       en;
  logic       sn_in;
  logic       busy;
  logic [4:0] z;
  logic [1:0] z_scaled;
  logic       z_valid;
  logic       z_ready;
  logic       ovr;

  int checks = 0;
  int errors = 0;

`ifdef DSC_DEC_ROUND_EN
  localparam int SCALED_TEN = 3;
`else
  localparam int SCALED_TEN = 2;
`endif

  dsc_stream_decoder #(.SNG_WIDTH(2), .NUM_INPUTS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .start    (start),
    .en       (en),
    .sn_in    (sn_in),
    .busy     (busy),
    .z        (z),
    .z_scaled (z_scaled),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs are applied 1 time unit after an edge, take effect on the next edge and are observed 1 unit after it.
  task automatic applyStimulus(input bit s, input bit e, input bit sn);
    start = s;
    en    = e;
    sn_in = sn;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    applyStimulus(0, 0, 0);
    clear = 1'b0;
  endtask

  // Runs one 16-sample window with the first 'ones' samples high; start is also held on the final sample.
  task automatic run_window(input int ones, input bit gaps, input bit prev_valid);
    applyStimulus(1, 0, 0);
    checkOutput("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 1);
        checkOutput("busy_in_gap", int'(busy), 1);
      end
      applyStimulus(i == 15, 1, i < ones);
      if (i == 14) begin
        checkOutput("valid_before_last", int'(z_valid), int'(prev_valid));
        checkOutput("busy_before_last", int'(busy), 1);
      end
    end
    checkOutput("valid_after_last", int'(z_valid), 1);
    checkOutput("busy_after_last", int'(busy), 0);
  endtask

  task automatic consume();
    z_ready = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("valid_after_consume", int'(z_valid), 0);
    z_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; start = 1'b0; en = 1'b0; sn_in = 1'b0; z_ready = 1'b0;
    #12;
    checkOutput("rst_z", int'(z), 0);
    checkOutput("rst_valid", int'(z_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ovr", int'(ovr), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] zero stream");
    run_window(0, 0, 0);
    checkOutput("zero_z", int'(z), 0);
    checkOutput("zero_scaled", int'(z_scaled), 0);
    applyStimulus(0, 0, 0);
    checkOutput("busy_stays_idle", int'(busy), 0);
    consume();

    $display("[TB] all ones");
    run_window(16, 0, 0);
    checkOutput("ones_z", int'(z), 16);
    checkOutput("ones_scaled", int'(z_scaled), 3);
    consume();

    $display("[TB] rescale");
    run_window(9, 0, 0);
    checkOutput("nine_z", int'(z), 9);
    checkOutput("nine_scaled", int'(z_scaled), 2);
    consume();
    run_window(10, 0, 0);
    checkOutput("ten_z", int'(z), 10);
    checkOutput("ten_scaled", int'(z_scaled), SCALED_TEN);
    consume();

    $display("[TB] en gaps");
    run_window(5, 1, 0);
    checkOutput("gaps_z", int'(z), 5);
    checkOutput("gaps_scaled", int'(z_scaled), 1);
    consume();

    $display("[TB] handshake and overrun");
    run_window(7, 0, 0);
    checkOutput("a_z", int'(z), 7);
    checkOutput("a_ovr", int'(ovr), 0);
    applyStimulus(0, 0, 0);
    checkOutput("a_held", int'(z_valid), 1);
    run_window(12, 0, 1);
    checkOutput("b_z", int'(z), 12);
    checkOutput("b_scaled", int'(z_scaled), 3);
    checkOutput("b_ovr", int'(ovr), 1);
    consume();
    checkOutput("ovr_sticky", int'(ovr), 1);
    pulse_clear();
    checkOutput("clear_ovr", int'(ovr), 0);

    $display("[TB] reset mid-window");
    run_window(3, 0, 0);
    checkOutput("pre_rst_z", int'(z), 3);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1);
    checkOutput("mid_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_z", int'(z), 0);
    checkOutput("async_rst_valid", int'(z_valid), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] clear mid-window");
    run_window(3, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1);
    pulse_clear();
    checkOutput("clear_z", int'(z), 0);
    checkOutput("clear_valid", int'(z_valid), 0);
    checkOutput("clear_busy", int'(busy), 0);
    run_window(4, 0, 0);
    checkOutput("after_clear_z", int'(z), 4);
    checkOutput("after_clear_scaled", int'(z_scaled), 1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsc_stream_decoder.md
Name: dsc_stream_decoder

Overview:
- Receiving end of the deterministic stochastic computing (DSC) serial datapath: converts one unary/stochastic bitstream back to binary.
- Counts ones over a deterministic window of 2^(NUM_INPUTS*SNG_WIDTH) enabled samples, the full period of a cascaded NUM_INPUTS-deep SNG chain.
- Presents the raw count and an SNG_WIDTH-bit rescaled value on a valid/ready output port, with overrun detection.
- Sits after the AND-combining logic of a serial DSC multiplier and replaces a free-running output counter with a framed, handshaked result.

Parameters:
SNG_WIDTH, 6, bit width of each SNG input operand and of the rescaled output
NUM_INPUTS, 3, number of cascaded SNGs feeding the stream; window exponent CW = NUM_INPUTS*SNG_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort/clear, active-high
start  input  1  begin a window (honoured only in IDLE)
en  input  1  sample enable; window advances only when high
sn_in  input  1  stochastic bitstream sample
busy  output  1  high while in RUN
z  output  CW+1  ones count of last completed window, range 0..2^CW
z_scaled  output  SNG_WIDTH  rescaled result
z_valid  output  1  result available
z_ready  input  1  consumer accepts result
ovr  output  1  sticky overrun flag

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While rst=0: state=IDLE, acc=0, wcnt=0, z=0, z_scaled=0, z_valid=0, ovr=0, busy=0.
- Internal: acc (CW+1 bits), wcnt (CW bits), 2-state FSM IDLE/RUN.
- Priority each edge: clear > window end > start.
- clear=1: state=IDLE, acc=0, wcnt=0, z=0, z_scaled=0, z_valid=0, ovr=0. Applies in any state, including mid-window.
- IDLE, start=1: state<=RUN, acc<=0, wcnt<=0. The first sample is taken on the following edge.
- RUN, en=1, wcnt<2^CW-1: acc<=acc+sn_in, wcnt<=wcnt+1.
- RUN, en=0: hold acc and wcnt. No gap limit.
- RUN, en=1, wcnt==2^CW-1 (window end): z<=acc+sn_in, z_scaled<=scale(acc+sn_in), z_valid<=1, state<=IDLE, wcnt wraps to 0. Latency is 1 cycle from the last sample to z_valid.
- start during RUN: ignored. start on the same edge as window end: ignored; the FSM lands in IDLE and needs a fresh start.
- Handshake:
  - Transfer occurs on an edge with z_valid=1 and z_ready=1; z_valid<=0 unless a window ends on the same edge.
  - z and z_scaled stay stable while z_valid=1 until transfer, except on overrun.
- Overrun: window end while z_valid=1 and z_ready=0 → new result overwrites z/z_scaled, z_valid stays 1, ovr<=1 (sticky until clear or reset).
- Window end with z_valid=1 and z_ready=1 on the same edge: no overrun; new result loaded, z_valid stays 1.
- scale(n), truncating: n >> (CW-SNG_WIDTH), saturated to 2^SNG_WIDTH-1 when n=2^CW.
- Arithmetic: acc never exceeds 2^CW, so CW+1 bits is sufficient and no wrap occurs. When CW==SNG_WIDTH the shift is 0 and only saturation applies.

Optional Feature:
- Macro: DSC_DEC_ROUND_EN.
- Defined: scale(n) = (n + 2^(CW-SNG_WIDTH-1)) >> (CW-SNG_WIDTH), saturated to 2^SNG_WIDTH-1. Rounds half up. Requires CW > SNG_WIDTH; otherwise it behaves as truncation.
- Undefined: pure truncation as above.
- z is unaffected in both cases.

Test Plan:
All scenarios use SNG_WIDTH=2, NUM_INPUTS=2 (CW=4, 16-sample window).
- Zero stream: start, 16 en cycles with sn_in=0 → z=0, z_scaled=0, z_valid high 1 cycle after 16th sample, busy low.
- All-ones: 16 samples sn_in=1 → z=16, z_scaled=3 (saturated), both with and without DSC_DEC_ROUND_EN.
- Rescale: 9 ones → z=9, z_scaled=2 in both modes; 10 ones → z_scaled=2 truncated, 3 with DSC_DEC_ROUND_EN.
- en gaps: 16 samples interleaved with random en=0 cycles, 5 ones → z=5; z_valid exactly 1 cycle after the 16th enabled sample; start pulses during RUN have no effect.
- Handshake/overrun:
  - z_ready=0, window A (z=7) completes.
  - Restart, window B (z=12) completes → z=12, z_valid=1, ovr=1.
  - z_ready=1 → z_valid drops next edge, ovr stays 1.
  - clear → ovr=0.
- Reset/clear mid-window: rst low after 8 samples → all outputs 0 immediately (asynchronous). Repeat with clear → IDLE next edge. A new start then yields a correct full 16-sample count.
